sync_fifo: RTL

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo_pkg.sv | 23 ++
 rtl/sync_fifo_mux.sv | 21 ++
 rtl/sync_fifo_reg.sv | 32 +++
 rtl/sync_fifo.sv | 124 ++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
//------------------------------------------------------------------------------
// Module   : sync_fifo_pkg
// Brief    : Shared types and helpers for the synchronous FIFO slice.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sync_fifo_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e decode_op(input logic push, input logic pop);
    return fifo_op_e'({push, pop});
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_mux.sv
//------------------------------------------------------------------------------
// Module   : sync_fifo_mux
// Brief    : Library N-input multiplexer with a binary select.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo_mux #(
  parameter int WIDTH  = 8,
  parameter int INPUTS = 4
) (
  input  logic [$clog2(INPUTS)-1:0]    sel,
  input  logic [INPUTS-1:0][WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]             out_data
);

  assign out_data = in_data[sel];

endmodule

`default_nettype wire

// File: rtl/sync_fifo_reg.sv
//------------------------------------------------------------------------------
// Module   : sync_fifo_reg
// Brief    : Library register: async reset to zero, sync clear, load enable.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // clear outranks en so a flush wins over a same-cycle load
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sync_fifo.sv
//------------------------------------------------------------------------------
// Module   : sync_fifo
// Brief    : First-word fall-through synchronous FIFO built from library
//            registers and a read-select mux.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]            r_wr_ptr;
  logic [PTR_W-1:0]            r_rd_ptr;
  logic [PTR_W-1:0]            w_wr_ptr_next;
  logic [PTR_W-1:0]            w_rd_ptr_next;
  logic [CNT_W-1:0]            r_count;
  logic [CNT_W-1:0]            w_count_next;
  logic                        w_count_en;
  logic [DEPTH-1:0][WIDTH-1:0] r_entry;
  logic                        w_push;
  logic                        w_pop;
  fifo_op_e                    w_op;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = r_count;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;
  assign w_op   = decode_op(w_push, w_pop);

  // DEPTH is a power of two, so natural overflow gives modulo-DEPTH wrap
  assign w_wr_ptr_next = r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr_next = r_rd_ptr + PTR_W'(1);

  always_comb begin
    w_count_next = r_count;
    w_count_en   = 1'b0;
    case (w_op)
      OP_PUSH: begin
        w_count_next = r_count + CNT_W'(1);
        w_count_en   = 1'b1;
      end
      OP_POP: begin
        w_count_next = r_count - CNT_W'(1);
        w_count_en   = 1'b1;
      end
      default: begin
        w_count_next = r_count;
        w_count_en   = 1'b0;
      end
    endcase
  end

  sync_fifo_reg #(.WIDTH(PTR_W)) u_wr_ptr (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .en    (w_push),
    .d     (w_wr_ptr_next),
    .q     (r_wr_ptr)
  );

  sync_fifo_reg #(.WIDTH(PTR_W)) u_rd_ptr (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .en    (w_pop),
    .d     (w_rd_ptr_next),
    .q     (r_rd_ptr)
  );

  sync_fifo_reg #(.WIDTH(CNT_W)) u_count (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .en    (w_count_en),
    .d     (w_count_next),
    .q     (r_count)
  );

  // Storage is never flushed by clear; a push coinciding with clear is dropped
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    sync_fifo_reg #(.WIDTH(WIDTH)) u_entry (
      .clock (clock),
      .reset (reset),
      .clear (1'b0),
      .en    (w_push && !clear && (r_wr_ptr == PTR_W'(i))),
      .d     (in_data),
      .q     (r_entry[i])
    );
  end

  sync_fifo_mux #(.WIDTH(WIDTH), .INPUTS(DEPTH)) u_rd_mux (
    .sel      (r_rd_ptr),
    .in_data  (r_entry),
    .out_data (out_data)
  );

endmodule

`default_nettype wire
